// File: rtl/sobel_pkg.sv
// Shared widths, types and arithmetic helpers for the sobel gradient-sum pipeline.
package sobel_pkg;

  localparam int TERM_W  = 8;
  localparam int CTERM_W = 9;
  localparam int GRAD_W  = 11;
  localparam int ABS_W   = 10;
  localparam int MAG_W   = 8;
  localparam logic [MAG_W-1:0] MAG_SAT = 8'd255;

  typedef logic signed [GRAD_W-1:0] grad_t;
  typedef logic [ABS_W-1:0]         abs_t;
  typedef logic [MAG_W-1:0]         mag_t;

  // |g| never exceeds 1020, so the low ABS_W bits of the negation are exact
  function automatic abs_t grad_abs(input grad_t g);
    grad_t neg_v;
    abs_t  res;
    neg_v = -g;
    if (g[GRAD_W-1]) res = neg_v[ABS_W-1:0];
    else             res = g[ABS_W-1:0];
    return res;
  endfunction

  function automatic mag_t sat_mag(input abs_t a, input abs_t b);
    logic [ABS_W:0] sum_v;
    mag_t           res;
    sum_v = {1'b0, a} + {1'b0, b};
    if (sum_v > {3'b000, MAG_SAT}) res = MAG_SAT;
    else                           res = sum_v[MAG_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/sobel_term_decode.sv
// Decodes one negative-coefficient term: a zero word means zero, otherwise the
// word is the low W bits of a negative value in -(2^W-1)..-1.
module sobel_term_decode
  import sobel_pkg::*;
#(
  parameter int W = TERM_W
) (
  input  logic [W-1:0]      d,
  output logic signed [W:0] v
);

  // Prepending a set sign bit turns the low bits back into d - 2^W
  always_comb begin
    v = {(W+1){1'b0}};
    if (d == {W{1'b0}}) v = {(W+1){1'b0}};
    else                v = {1'b1, d};
  end

endmodule

// File: rtl/sobel_grad_sum.sv
// Three-stage Sobel gradient magnitude pipeline with valid/ready flow control.
// Optional per-frame edge-pixel counter enabled by SOBEL_EDGE_CNT_EN.
module sobel_grad_sum
  import sobel_pkg::*;
#(
  parameter int CNT_W = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sof,
  input  logic [TERM_W-1:0]  gx_n1,
  input  logic [TERM_W-1:0]  gx_n2,
  input  logic [CTERM_W-1:0] gx_n3,
  input  logic [TERM_W-1:0]  gx_p1,
  input  logic [TERM_W-1:0]  gx_p2,
  input  logic [CTERM_W-1:0] gx_p3,
  input  logic [TERM_W-1:0]  gy_n1,
  input  logic [TERM_W-1:0]  gy_n2,
  input  logic [CTERM_W-1:0] gy_n3,
  input  logic [TERM_W-1:0]  gy_p1,
  input  logic [TERM_W-1:0]  gy_p2,
  input  logic [CTERM_W-1:0] gy_p3,
  input  logic [MAG_W-1:0]   thresh,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [MAG_W-1:0]   out_mag,
  output logic               out_edge,
  output logic               out_sof
`ifdef SOBEL_EDGE_CNT_EN
  ,
  output logic [CNT_W-1:0]   edge_cnt
`endif
);

  logic s1_valid_r, s2_valid_r, s3_valid_r;
  logic en1_s, en2_s, en3_s;

  logic signed [TERM_W:0]  gxn1_s, gxn2_s, gyn1_s, gyn2_s;
  logic signed [CTERM_W:0] gxn3_s, gyn3_s;

  abs_t  gx_pos_r, gy_pos_r;
  grad_t gx_neg_r, gy_neg_r;
  mag_t  thresh1_r, thresh2_r;
  logic  sof1_r, sof2_r;
  abs_t  gx_abs_r, gy_abs_r;
  grad_t gx_s, gy_s;
  mag_t  mag_s;

  sobel_term_decode #(.W(TERM_W))  u_dec_gxn1 (.d(gx_n1), .v(gxn1_s));
  sobel_term_decode #(.W(TERM_W))  u_dec_gxn2 (.d(gx_n2), .v(gxn2_s));
  sobel_term_decode #(.W(CTERM_W)) u_dec_gxn3 (.d(gx_n3), .v(gxn3_s));
  sobel_term_decode #(.W(TERM_W))  u_dec_gyn1 (.d(gy_n1), .v(gyn1_s));
  sobel_term_decode #(.W(TERM_W))  u_dec_gyn2 (.d(gy_n2), .v(gyn2_s));
  sobel_term_decode #(.W(CTERM_W)) u_dec_gyn3 (.d(gy_n3), .v(gyn3_s));

  // A stage may load when it is empty or its content is moving on this cycle
  assign en3_s     = !s3_valid_r || out_ready;
  assign en2_s     = !s2_valid_r || en3_s;
  assign en1_s     = !s1_valid_r || en2_s;
  assign in_ready  = en1_s;
  assign out_valid = s3_valid_r;

  assign gx_s  = $signed({1'b0, gx_pos_r}) + gx_neg_r;
  assign gy_s  = $signed({1'b0, gy_pos_r}) + gy_neg_r;
  assign mag_s = sat_mag(gx_abs_r, gy_abs_r);

  // Stage valid bits
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
      s3_valid_r <= 1'b0;
    end else begin
      if (en1_s) s1_valid_r <= in_valid;
      if (en2_s) s2_valid_r <= s1_valid_r;
      if (en3_s) s3_valid_r <= s2_valid_r;
    end
  end

  // Stage 1: positive and negative partial sums per axis
  always_ff @(posedge clk) begin
    if (rst) begin
      gx_pos_r  <= {ABS_W{1'b0}};
      gy_pos_r  <= {ABS_W{1'b0}};
      gx_neg_r  <= {GRAD_W{1'b0}};
      gy_neg_r  <= {GRAD_W{1'b0}};
      thresh1_r <= {MAG_W{1'b0}};
      sof1_r    <= 1'b0;
    end else if (en1_s && in_valid) begin
      gx_pos_r  <= {2'b00, gx_p1} + {2'b00, gx_p2} + {1'b0, gx_p3};
      gy_pos_r  <= {2'b00, gy_p1} + {2'b00, gy_p2} + {1'b0, gy_p3};
      gx_neg_r  <= {{2{gxn1_s[TERM_W]}}, gxn1_s} + {{2{gxn2_s[TERM_W]}}, gxn2_s}
                 + {gxn3_s[CTERM_W], gxn3_s};
      gy_neg_r  <= {{2{gyn1_s[TERM_W]}}, gyn1_s} + {{2{gyn2_s[TERM_W]}}, gyn2_s}
                 + {gyn3_s[CTERM_W], gyn3_s};
      thresh1_r <= thresh;
      sof1_r    <= in_sof;
    end
  end

  // Stage 2: per-axis absolute gradients
  always_ff @(posedge clk) begin
    if (rst) begin
      gx_abs_r  <= {ABS_W{1'b0}};
      gy_abs_r  <= {ABS_W{1'b0}};
      thresh2_r <= {MAG_W{1'b0}};
      sof2_r    <= 1'b0;
    end else if (en2_s && s1_valid_r) begin
      gx_abs_r  <= grad_abs(gx_s);
      gy_abs_r  <= grad_abs(gy_s);
      thresh2_r <= thresh1_r;
      sof2_r    <= sof1_r;
    end
  end

  // Stage 3: saturated magnitude and edge flag, frozen while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      out_mag  <= {MAG_W{1'b0}};
      out_edge <= 1'b0;
      out_sof  <= 1'b0;
    end else if (en3_s && s2_valid_r) begin
      out_mag  <= mag_s;
      out_edge <= (mag_s >= thresh2_r);
      out_sof  <= sof2_r;
    end
  end

`ifdef SOBEL_EDGE_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Per-frame edge count, restarted by each start-of-frame output beat
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt <= {CNT_W{1'b0}};
    end else if (s3_valid_r && out_ready) begin
      if (out_sof)
        edge_cnt <= {{(CNT_W-1){1'b0}}, out_edge};
      else if (out_edge && (edge_cnt != CNT_MAX))
        edge_cnt <= edge_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
`endif

endmodule

// File: tb/tb_sobel_grad_sum.sv
// Self-checking bench for sobel_grad_sum: directed corner cases plus randomized
// traffic scored against an arithmetic reference model.
module tb_sobel_grad_sum;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_sof;
  logic [7:0] gx_n1, gx_n2, gx_p1, gx_p2, gy_n1, gy_n2, gy_p1, gy_p2;
  logic [8:0] gx_n3, gx_p3, gy_n3, gy_p3;
  logic [7:0] thresh;
  logic       out_valid, out_ready;
  logic [7:0] out_mag;
  logic       out_edge, out_sof;
`ifdef SOBEL_EDGE_CNT_EN
  logic [19:0] edge_cnt;
`endif

  sobel_grad_sum #(.CNT_W(20)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .gx_n1(gx_n1), .gx_n2(gx_n2), .gx_n3(gx_n3), .gx_p1(gx_p1), .gx_p2(gx_p2), .gx_p3(gx_p3),
    .gy_n1(gy_n1), .gy_n2(gy_n2), .gy_n3(gy_n3), .gy_p1(gy_p1), .gy_p2(gy_p2), .gy_p3(gy_p3),
    .thresh(thresh), .out_valid(out_valid), .out_ready(out_ready),
    .out_mag(out_mag), .out_edge(out_edge), .out_sof(out_sof)
`ifdef SOBEL_EDGE_CNT_EN
    , .edge_cnt(edge_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] mag;
    logic       edg;
    logic       sof;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_out = 0;
  int   cnt_m = 0;
  logic last_acc;
  logic last_in_ready;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic int dneg(input int d, input int span);
    return (d == 0) ? 0 : d - span;
  endfunction

  // Reference: Gx/Gy as plain integer sums, magnitude clipped at 255
  function automatic exp_t model_now();
    exp_t r;
    int gx, gy, m;
    gx = int'(gx_p1) + int'(gx_p2) + int'(gx_p3)
       + dneg(int'(gx_n1), 256) + dneg(int'(gx_n2), 256) + dneg(int'(gx_n3), 512);
    gy = int'(gy_p1) + int'(gy_p2) + int'(gy_p3)
       + dneg(int'(gy_n1), 256) + dneg(int'(gy_n2), 256) + dneg(int'(gy_n3), 512);
    m = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
    if (m > 255) m = 255;
    r.mag = 8'(m);
    r.edg = (m >= int'(thresh));
    r.sof = in_sof;
    return r;
  endfunction

  // One clock: score output transfer, record input transfer, check stall hold
  task automatic tick();
    exp_t e;
    logic hold;
    logic [9:0] snap;
    #1;
    hold = 1'b0;
    snap = 10'd0;
    last_in_ready = in_ready;
    last_acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("out_mag", out_mag, e.mag);
        chk("out_edge", out_edge, e.edg);
        chk("out_sof", out_sof, e.sof);
        if (e.sof) cnt_m = e.edg;
        else if (e.edg && cnt_m < (1 << 20) - 1) cnt_m++;
      end
    end else if (out_valid) begin
      hold = 1'b1;
      snap = {out_mag, out_edge, out_sof};
    end
    if (last_acc) exp_q.push_back(model_now());
    @(posedge clk);
    #1;
    if (hold) begin
      chk("hold_valid", out_valid, 32'd1);
      chk("hold_data", {out_mag, out_edge, out_sof}, snap);
    end
`ifdef SOBEL_EDGE_CNT_EN
    chk("edge_cnt", edge_cnt, cnt_m);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 32'd0);
    chk("rst_out_mag", out_mag, 32'd0);
    chk("rst_out_edge", out_edge, 32'd0);
    chk("rst_out_sof", out_sof, 32'd0);
`ifdef SOBEL_EDGE_CNT_EN
    chk("rst_edge_cnt", edge_cnt, 32'd0);
`endif
    rst = 1'b0;
    exp_q.delete();
    cnt_m = 0;
    #1;
    chk("rst_in_ready", in_ready, 32'd1);
  endtask

  task automatic set_beat(input int xn1, input int xn2, input int xn3, input int xp1,
                          input int xp2, input int xp3, input int yn1, input int yn2,
                          input int yn3, input int yp1, input int yp2, input int yp3,
                          input int thr, input logic sof);
    gx_n1 = 8'(xn1); gx_n2 = 8'(xn2); gx_n3 = 9'(xn3);
    gx_p1 = 8'(xp1); gx_p2 = 8'(xp2); gx_p3 = 9'(xp3);
    gy_n1 = 8'(yn1); gy_n2 = 8'(yn2); gy_n3 = 9'(yn3);
    gy_p1 = 8'(yp1); gy_p2 = 8'(yp2); gy_p3 = 9'(yp3);
    thresh = 8'(thr);
    in_sof = sof;
  endtask

  function automatic int pix(input int base);
    int v;
    v = base + $urandom_range(0, 40) - 20;
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return v;
  endfunction

  task automatic rand_beat(input logic sof);
    int b;
    if ($urandom_range(0, 1) == 1) begin
      set_beat($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 511),
               $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 511),
               $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 511),
               $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 511),
               $urandom_range(0, 255), sof);
    end else begin
      b = $urandom_range(0, 255);
      set_beat(256 - pix(b), 256 - pix(b), 512 - 2 * pix(b), pix(b), pix(b), 2 * pix(b),
               256 - pix(b), 256 - pix(b), 512 - 2 * pix(b), pix(b), pix(b), 2 * pix(b),
               $urandom_range(0, 80), sof);
    end
  endtask

  // Single beat with out_ready high: exact 3-cycle latency and expected result
  task automatic one_beat(input string tag, input int mag, input int edg);
    in_valid = 1'b1;
    tick();
    chk({tag, "_acc"}, last_acc, 32'd1);
    in_valid = 1'b0;
    tick();
    chk({tag, "_lat2"}, out_valid, 32'd0);
    tick();
    chk({tag, "_lat3"}, out_valid, 32'd1);
    chk({tag, "_mag"}, out_mag, mag);
    chk({tag, "_edge"}, out_edge, edg);
    tick();
  endtask

  initial begin
    int sent, out0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    set_beat(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    do_reset();

    set_beat(206, 206, 412, 50, 50, 100, 206, 206, 412, 50, 50, 100, 128, 1'b1);
    one_beat("flat", 0, 0);
    set_beat(0, 0, 0, 255, 255, 510, 0, 0, 0, 0, 0, 0, 128, 1'b0);
    one_beat("vedge", 255, 1);
    set_beat(246, 0, 0, 10, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1'b0);
    one_beat("small0", 0, 0);
    set_beat(246, 0, 0, 20, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1'b0);
    one_beat("small10", 10, 1);
    set_beat(246, 0, 0, 20, 0, 0, 0, 0, 0, 0, 0, 0, 10, 1'b0);
    one_beat("thr_eq", 10, 1);
    set_beat(246, 0, 0, 20, 0, 0, 0, 0, 0, 0, 0, 0, 11, 1'b0);
    one_beat("thr_above", 10, 0);
    set_beat(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 200, 1'b0);
    one_beat("neg_max", 255, 1);
    set_beat(0, 0, 0, 0, 0, 0, 156, 0, 0, 0, 0, 0, 100, 1'b0);
    one_beat("gy_only", 100, 1);

    // Backpressure: six beats, consumer stalled for cycles 2..7
    sent = 0;
    out0 = n_out;
    for (int i = 0; i < 40 && (sent < 6 || exp_q.size() > 0); i++) begin
      out_ready = !(i >= 2 && i <= 7);
      if (!in_valid && sent < 6) begin
        rand_beat(1'b0);
        in_valid = 1'b1;
      end
      tick();
      if (last_acc) begin
        sent++;
        in_valid = 1'b0;
      end
      if (i == 3) begin
        chk("bp_in_ready_low", last_in_ready, 32'd0);
        chk("bp_buffered", sent, 32'd3);
      end
    end
    chk("bp_out_count", n_out - out0, 32'd6);
    out_ready = 1'b1;

    // Mid-stream reset after two accepted beats
    rand_beat(1'b0);
    in_valid = 1'b1;
    tick();
    rand_beat(1'b0);
    tick();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_no_out", out_valid, 32'd0);
    end
    set_beat(0, 0, 0, 30, 0, 0, 0, 0, 0, 0, 0, 0, 30, 1'b1);
    one_beat("post_rst", 30, 1);

`ifdef SOBEL_EDGE_CNT_EN
    // Frame of four beats with edges 1,0,1,1, then a new frame with edge 0
    for (int k = 0; k < 5; k++) begin
      if (k == 1 || k == 4)
        set_beat(206, 206, 412, 50, 50, 100, 206, 206, 412, 50, 50, 100, 128, k == 4);
      else
        set_beat(0, 0, 0, 255, 255, 510, 0, 0, 0, 0, 0, 0, 128, k == 0);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int j = 0; j < 3; j++) tick();
      if (k == 3) chk("frame_cnt3", edge_cnt, 32'd3);
      if (k == 4) chk("frame_cnt0", edge_cnt, 32'd0);
    end
`endif

    // Randomized traffic with random stalls and start-of-frame markers
    for (int i = 0; i < 800; i++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        rand_beat($urandom_range(0, 7) == 0);
        in_valid = 1'b1;
      end
      tick();
      if (last_acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
    chk("drain_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sobel_grad_sum.md
SOBEL_GRAD_SUM -- requirements
Module: sobel_grad_sum

Interface
REQ-001 Parameter CNT_W, default 20: width of the edge-pixel counter.
REQ-002 clk  in  1  single clock; all logic rising-edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 in_valid / in_ready  in / out  1 / 1  input beat handshake; transfer when both are high.
REQ-005 in_sof  in  1  beat is first pixel of a frame.
REQ-006 gx_n1, gx_n2  in  8 each  Gx negative-coefficient terms, low 8 bits of two's-complement (-p).
REQ-007 gx_n3  in  9  Gx centre negative term, low 9 bits of (-2p).
REQ-008 gx_p1, gx_p2 (8) and gx_p3 (9)  in  Gx positive terms p, p, 2p.
REQ-009 gy_n1, gy_n2, gy_n3, gy_p1, gy_p2, gy_p3  in  8/8/9/8/8/9  same encoding for Gy.
REQ-010 thresh  in  8  edge threshold, sampled with each accepted beat.
REQ-011 out_valid / out_ready  out / in  1 / 1  output handshake.
REQ-012 out_mag  out  8  saturated gradient magnitude.
REQ-013 out_edge  out  1  out_mag >= sampled thresh.
REQ-014 out_sof  out  1  in_sof delayed with its beat.
REQ-015 edge_cnt  out  CNT_W  edge pixels in current frame (present only with macro, REQ-031).

Function
REQ-016 Negative 8-bit term d decodes to 0 when d==0, else d-256; negative 9-bit term decodes to 0 when d==0, else d-512.
REQ-017 Positive terms are zero-extended unsigned.
REQ-018 Gx = sum of six decoded Gx terms, Gy likewise; signed 11-bit internal, range -1020..+1020, no overflow.
REQ-019 Stage 1 registers decoded partial sums (pos sum, neg sum per axis) with thresh and sof.
REQ-020 Stage 2 registers |Gx| and |Gy| (unsigned 10-bit).
REQ-021 Stage 3 registers out_mag = min(|Gx|+|Gy|, 255), out_edge, out_sof.
REQ-022 Latency exactly 3 cycles from accepted input to out_valid when out_ready held high.
REQ-023 Each stage holds a valid bit; stage advances when its successor is empty or advancing; in_ready = !stage1_valid or stage1 advancing.
REQ-024 Full throughput: one beat per cycle with out_ready high continuously.
REQ-025 out_ready low: out_* stable, no beat dropped or duplicated, order preserved; at most 3 beats buffered, then in_ready low.
REQ-026 out_mag, out_edge, out_sof don't-care while out_valid low but shall not change while out_valid high and out_ready low.

Reset
REQ-027 rst clears all stage valid bits; out_valid=0, out_mag=0, out_edge=0, out_sof=0, edge_cnt=0 on the next edge.
REQ-028 in_ready=1 the cycle after rst deasserts.
REQ-029 rst mid-stream discards all in-flight beats; no output beat emitted from pre-reset data.

Configuration
REQ-030 Macro SOBEL_EDGE_CNT_EN selects the frame edge counter.
REQ-031 Defined: edge_cnt port exists; on each output transfer, edge_cnt loads out_edge if out_sof, else increments by out_edge; saturates at 2^CNT_W-1.
REQ-032 Undefined: edge_cnt port and counter logic absent; all other behaviour identical.

Structure
REQ-033 Shared package sobel_pkg: term widths (8, 9), gradient width 11, magnitude width 8, saturation constant 255.
REQ-034 One sub-module sobel_term_decode: decodes one negative term of parameterised width per REQ-016; instantiated six times.

Verification
REQ-035 Flat 50: n1=n2=206, n3=412, p1=p2=50, p3=100 both axes, thresh=128 -> out_mag=0, out_edge=0 after 3 cycles.
REQ-036 Vertical edge: gx_n*=0, gx_p=255/255/510, gy all zero -> Gx=1020, out_mag=255, out_edge=1; zero negatives must not decode as -256.
REQ-037 Small gradient: gx_p1=10, gx_n1=246 (-10), all else 0, thresh=1 -> out_mag=0, out_edge=0; gx_p1=20 instead -> out_mag=10, out_edge=1.
REQ-038 Backpressure: stream 6 beats, out_ready low cycles 2-7 -> in_ready low after 3 buffered beats, all 6 outputs in order, none lost.
REQ-039 Reset after 2 beats accepted -> no out_valid until new beats, first new beat emerges 3 cycles after acceptance.
REQ-040 With SOBEL_EDGE_CNT_EN: frame of 4 beats, edges 1,0,1,1 with sof on first -> edge_cnt=3; next sof beat with edge 0 -> edge_cnt=0.
